// File: rtl/health_tracker.sv
// health_tracker: player life bookkeeping.
// Turns the per-barrel collision vector into single hit events, decides
// whether the shield absorbs a hit or a life is lost, runs the post-hit
// invulnerability window with its blink toggle and flags game over.
// Every output is a flop; state_dbg mirrors the FSM state register.
module health_tracker #(
    parameter int LIVES         = 3,
    parameter int INVULN_CYCLES = 65_000_000,
    parameter int BLINK_CYCLES  = 8_125_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_game,
    input  logic [9:0] hit,
    input  logic       is_shielded,
    output logic [2:0] lives,
    output logic       invulnerable,
    output logic       blink,
    output logic       shield_absorbed,
    output logic       game_over,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALIVE  = 2'd1,
        S_INVULN = 2'd2,
        S_DEAD   = 2'd3
    } state_t;

    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
    localparam logic [31:0] INV_LAST   = 32'(INVULN_CYCLES - 1);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);

    state_t      state, state_nx;
    logic        hit_any, hit_any_q, hit_evt;
    logic [31:0] cnt, cnt_nx;
    logic [31:0] bcnt, bcnt_nx;
    logic [2:0]  lives_nx;
    logic        inv_nx, blink_nx, abs_nx, go_nx;

    // A collision held over several cycles must count once, so only the
    // rising edge of the OR-reduced vector is an event. Several bits rising
    // together collapse into that single edge.
    assign hit_any = |hit;
    assign hit_evt = hit_any & ~hit_any_q;

    assign state_dbg = state;

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            hit_any_q       <= 1'b0;
            cnt             <= '0;
            bcnt            <= '0;
            lives           <= LIVES_INIT;
            invulnerable    <= 1'b0;
            blink           <= 1'b0;
            shield_absorbed <= 1'b0;
            game_over       <= 1'b0;
        end else begin
            state           <= state_nx;
            hit_any_q       <= hit_any;
            cnt             <= cnt_nx;
            bcnt            <= bcnt_nx;
            lives           <= lives_nx;
            invulnerable    <= inv_nx;
            blink           <= blink_nx;
            shield_absorbed <= abs_nx;
            game_over       <= go_nx;
        end
    end

    // Next-state and next-output logic. Dropping start_game overrides
    // everything, including a hit arriving in the same cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bcnt_nx  = bcnt;
        lives_nx = lives;
        inv_nx   = invulnerable;
        blink_nx = blink;
        abs_nx   = 1'b0;
        go_nx    = game_over;

        if (!start_game) begin
            state_nx = S_IDLE;
            lives_nx = LIVES_INIT;
            cnt_nx   = '0;
            bcnt_nx  = '0;
            inv_nx   = 1'b0;
            blink_nx = 1'b0;
            go_nx    = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    lives_nx = LIVES_INIT;
                    inv_nx   = 1'b0;
                    blink_nx = 1'b0;
                    go_nx    = 1'b0;
                    state_nx = S_ALIVE;
                end

                S_ALIVE: begin
                    if (hit_evt) begin
                        if (is_shielded) begin
                            abs_nx   = 1'b1;
                            state_nx = S_INVULN;
                            inv_nx   = 1'b1;
                            cnt_nx   = '0;
                            bcnt_nx  = '0;
                            blink_nx = 1'b0;
                        end else if (lives <= 3'd1) begin
                            // Last life: go straight to DEAD with no window.
                            lives_nx = 3'd0;
                            state_nx = S_DEAD;
                            go_nx    = 1'b1;
                        end else begin
                            lives_nx = lives - 3'd1;
                            state_nx = S_INVULN;
                            inv_nx   = 1'b1;
                            cnt_nx   = '0;
                            bcnt_nx  = '0;
                            blink_nx = 1'b0;
                        end
                    end
                end

                S_INVULN: begin
                    // Hit edges are ignored here; hit_any_q keeps tracking, so
                    // a collision still held at exit is not a new edge.
                    if (cnt == INV_LAST) begin
                        state_nx = S_ALIVE;
                        cnt_nx   = '0;
                        bcnt_nx  = '0;
                        inv_nx   = 1'b0;
                        blink_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + 32'd1;
                        // bcnt tracks the position inside the current blink
                        // half-period, avoiding a modulo on cnt.
                        if (bcnt == BLINK_LAST) begin
                            bcnt_nx  = '0;
                            blink_nx = ~blink;
                        end else begin
                            bcnt_nx = bcnt + 32'd1;
                        end
                    end
                end

                S_DEAD: begin
                    lives_nx = 3'd0;
                    go_nx    = 1'b1;
                end

                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker with LIVES=3, INVULN_CYCLES=8,
// BLINK_CYCLES=2. The driver applies one input vector per cycle at the
// falling edge and queues the outputs expected after the next rising edge;
// the monitor pops and compares 1 ns after every rising edge.
module tb_health_tracker;

    localparam int LIVES = 3;
    localparam int IC    = 8;
    localparam int BC    = 2;

    // ---------------- clock / reset ----------------
    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       start_game  = 1'b0;
    logic       is_shielded = 1'b0;
    logic [9:0] hit         = '0;
    logic [2:0] lives;
    logic       invulnerable, blink, shield_absorbed, game_over;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    health_tracker #(
        .LIVES        (LIVES),
        .INVULN_CYCLES(IC),
        .BLINK_CYCLES (BC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_game     (start_game),
        .hit            (hit),
        .is_shielded    (is_shielded),
        .lives          (lives),
        .invulnerable   (invulnerable),
        .blink          (blink),
        .shield_absorbed(shield_absorbed),
        .game_over      (game_over),
        .state_dbg      (state_dbg)
    );

    // Packed view: {lives, invulnerable, blink, shield_absorbed, game_over}
    logic [6:0] act;
    assign act = {lives, invulnerable, blink, shield_absorbed, game_over};

    // ---------------- scoreboard ----------------
    logic [6:0] exp_q[$];
    int         id_q[$];
    int         n_cmp   = 0;
    int         n_err   = 0;
    int         step_no = 0;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [6:0] e;
            int         id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_err++;
                $display("FAIL step%0d: got lives=%0d inv=%b blink=%b abs=%b go=%b, want lives=%0d inv=%b blink=%b abs=%b go=%b",
                         id, act[6:4], act[3], act[2], act[1], act[0],
                         e[6:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic sg, input logic [9:0] h, input logic sh,
                        input logic [2:0] el, input logic ei, input logic eb,
                        input logic ea, input logic eg);
        @(negedge clk);
        start_game  = sg;
        hit         = h;
        is_shielded = sh;
        exp_q.push_back({el, ei, eb, ea, eg});
        id_q.push_back(step_no);
        step_no++;
    endtask

    // Hit edge at k=0, then the 8-cycle window and the exit cycle (k=8).
    // on[k] says whether hv is driven during step k.
    task automatic hit_window(input logic [9:0] hv, input logic [8:0] on, input logic sh,
                              input logic [2:0] el, input logic ea);
        logic [7:0] pat;
        pat = 8'b1100_1100;  // blink after entering cycle k: 0,0,1,1,0,0,1,1
        for (int k = 0; k < 8; k++)
            step(1'b1, on[k] ? hv : 10'h000, sh, el, 1'b1, pat[k], (k == 0) ? ea : 1'b0, 1'b0);
        step(1'b1, on[8] ? hv : 10'h000, sh, el, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b0;
        #1;
        check_now("reset_outputs", 32'(act), 32'({3'd3, 4'b0000}));
        check_now("reset_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic hit, collision held 5 cycles
        step(1'b1, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        hit_window(10'h001, 9'h01F, 1'b0, 3'd2, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Restart, then shield absorb
        step(1'b0, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        hit_window(10'h200, 9'h001, 1'b1, 3'd3, 1'b1);
        step(1'b1, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Second edge 3 cycles in is ignored; edge 10 cycles in counts
        hit_window(10'h001, 9'h009, 1'b0, 3'd2, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        hit_window(10'h001, 9'h001, 1'b0, 3'd1, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Death: three hits 12 cycles apart
        step(1'b0, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        hit_window(10'h002, 9'h001, 1'b0, 3'd2, 1'b0);
        repeat (3) step(1'b1, 10'h000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        hit_window(10'h002, 9'h001, 1'b0, 3'd1, 1'b0);
        repeat (3) step(1'b1, 10'h000, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h002, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 10'h000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 10'h3FF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 10'h000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 10'h001, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // All bits rising together, held past the window exit
        hit_window(10'h3FF, 9'h1FF, 1'b0, 3'd2, 1'b0);
        step(1'b1, 10'h3FF, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hit in the same cycle as start_game falling is dropped
        step(1'b0, 10'h001, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Async reset in the middle of the window, with blink high
        step(1'b1, 10'h004, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h000, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_now("async_rst_outputs", 32'(act), 32'({3'd3, 4'b0000}));
        check_now("async_rst_state", 32'(state_dbg), 32'd0);
        start_game = 1'b0;
        hit        = 10'h000;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_now("post_release_state", 32'(state_dbg), 32'd0);
        step(1'b1, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h001, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'h000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- report ----------------
        repeat (3) @(negedge clk);
        check_now("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
